// File: rtl/game_if.sv
// Chip Invaders sequencer bus: pixel/frame inputs toward the sequencer, game status back.
interface game_if;
  logic       vsync;
  logic       display_on;
  logic       laser_gfx;
  logic       alien_pixel;
  logic       bomb_gfx;
  logic       cannon_gfx;
  logic       aliens_cleared;
  logic       aliens_landed;
  logic       btn_start;
  logic       hit_alien;
  logic [7:0] score;
  logic [1:0] lives;
  logic [3:0] wave;
  logic       play_en;
  logic       formation_rst;
  logic       cannon_rst;
  logic [2:0] game_state;

  modport master (
    output vsync, display_on, laser_gfx, alien_pixel, bomb_gfx, cannon_gfx,
           aliens_cleared, aliens_landed, btn_start,
    input  hit_alien, score, lives, wave, play_en, formation_rst, cannon_rst, game_state
  );

  modport slave (
    input  vsync, display_on, laser_gfx, alien_pixel, bomb_gfx, cannon_gfx,
           aliens_cleared, aliens_landed, btn_start,
    output hit_alien, score, lives, wave, play_en, formation_rst, cannon_rst, game_state
  );
endinterface

// File: rtl/game_sequencer.sv
// Frame-level Chip Invaders controller: collision latching during scan-out,
// once-per-frame commit of score/lives/wave and the game state machine.
module game_sequencer #(
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned POINTS_PER_ALIEN = 1,
  parameter int unsigned DEATH_FRAMES     = 60,
  parameter int unsigned CLEAR_FRAMES     = 90
) (
  input logic  clk,
  input logic  reset,
  game_if.slave bus
);

  localparam int unsigned TIMER_W = 7;

  if (START_LIVES < 1 || START_LIVES > 3 ||
      DEATH_FRAMES < 1 || DEATH_FRAMES > 127 ||
      CLEAR_FRAMES < 1 || CLEAR_FRAMES > 127) begin : g_param_check
    $error("game_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_DYING      = 3'd2,
    ST_WAVE_CLEAR = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  state_t               state;
  logic                 vsync_q;
  logic                 lhit;
  logic                 chit;
  logic                 released;
  logic [TIMER_W-1:0]   timer;
  logic [7:0]           score_q;
  logic [1:0]           lives_q;
  logic [3:0]           wave_q;
  logic                 hit_q;
  logic                 frst_q;
  logic                 crst_q;
  logic                 play_q;

  logic                 frame_tick;
  logic                 in_play;
  logic                 laser_now;
  logic                 bomb_now;
  logic [8:0]           score_sum;
  logic [TIMER_W-1:0]   timer_inc;

  assign frame_tick = bus.vsync & ~vsync_q;
  assign in_play    = (state == ST_PLAY);
  assign laser_now  = bus.display_on & bus.laser_gfx & bus.alien_pixel;
  assign bomb_now   = bus.display_on & bus.bomb_gfx & bus.cannon_gfx;
  assign score_sum  = {1'b0, score_q} + 9'(POINTS_PER_ALIEN);
  assign timer_inc  = (timer == {TIMER_W{1'b1}}) ? timer : timer + TIMER_W'(1);

  assign bus.hit_alien     = hit_q;
  assign bus.score         = score_q;
  assign bus.lives         = lives_q;
  assign bus.wave          = wave_q;
  assign bus.play_en       = play_q;
  assign bus.formation_rst = frst_q;
  assign bus.cannon_rst    = crst_q;
  assign bus.game_state    = state;

  // Frame edge detect and per-frame collision latches; a hit on the tick cycle starts the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      lhit    <= 1'b0;
      chit    <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      if (frame_tick) begin
        lhit <= in_play & laser_now;
        chit <= in_play & bomb_now;
      end else begin
        if (in_play & laser_now) lhit <= 1'b1;
        if (in_play & bomb_now)  chit <= 1'b1;
      end
    end
  end

  // Game state machine; every commit happens on frame_tick, pulses last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      score_q  <= 8'd0;
      lives_q  <= 2'(START_LIVES);
      wave_q   <= 4'd0;
      timer    <= '0;
      released <= 1'b0;
      hit_q    <= 1'b0;
      frst_q   <= 1'b0;
      crst_q   <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      frst_q <= 1'b0;
      crst_q <= 1'b0;
      if (frame_tick) begin
        case (state)
          ST_IDLE: begin
            if (bus.btn_start) begin
              state   <= ST_PLAY;
              score_q <= 8'd0;
              lives_q <= 2'(START_LIVES);
              wave_q  <= 4'd0;
              frst_q  <= 1'b1;
              crst_q  <= 1'b1;
              play_q  <= 1'b1;
            end
          end
          ST_PLAY: begin
            if (bus.aliens_landed) begin
              state    <= ST_GAME_OVER;
              lives_q  <= 2'd0;
              released <= 1'b0;
              play_q   <= 1'b0;
            end else begin
              if (lhit) begin
                hit_q   <= 1'b1;
                score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
              end
              if (chit) begin
                lives_q <= lives_q - 2'd1;
                timer   <= '0;
                play_q  <= 1'b0;
                if (lives_q == 2'd1) begin
                  state    <= ST_GAME_OVER;
                  released <= 1'b0;
                end else begin
                  state <= ST_DYING;
                end
              end else if (bus.aliens_cleared) begin
                state  <= ST_WAVE_CLEAR;
                timer  <= '0;
                play_q <= 1'b0;
              end
            end
          end
          ST_DYING: begin
            if (timer == TIMER_W'(DEATH_FRAMES - 1)) begin
              state  <= ST_PLAY;
              timer  <= '0;
              crst_q <= 1'b1;
              play_q <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end
          ST_WAVE_CLEAR: begin
            if (timer == TIMER_W'(CLEAR_FRAMES - 1)) begin
              state  <= ST_PLAY;
              timer  <= '0;
              wave_q <= wave_q + 4'd1;
              frst_q <= 1'b1;
              play_q <= 1'b1;
            end else begin
              timer <= timer_inc;
            end
          end
          ST_GAME_OVER: begin
            if (!bus.btn_start) begin
              released <= 1'b1;
            end else if (released) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            play_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed, table-driven bench for game_sequencer.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_if bus();

  game_sequencer #(
    .START_LIVES(3),
    .POINTS_PER_ALIEN(1),
    .DEATH_FRAMES(60),
    .CLEAR_FRAMES(90)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int btn; int nl; int nb; int dis; int clr; int land; int reps;
    int st; int sc; int lv; int wv; int h; int f; int c; int p;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int errors = 0;
  int checks = 0;
  int hit_cycles = 0;
  int exp_hits = 0;

  // Count every cycle hit_alien is high to prove single-cycle pulses.
  always @(negedge clk) begin
    if (bus.hit_alien === 1'b1) hit_cycles <= hit_cycles + 1;
  end

  function automatic vec_t mk(int btn, int nl, int nb, int dis, int clr, int land, int reps,
                              int st, int sc, int lv, int wv, int h, int f, int c, int p);
    vec_t v;
    v.btn = btn; v.nl = nl; v.nb = nb; v.dis = dis; v.clr = clr; v.land = land; v.reps = reps;
    v.st = st; v.sc = sc; v.lv = lv; v.wv = wv; v.h = h; v.f = f; v.c = c; v.p = p;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_pixels();
    bus.display_on  = 1'b0;
    bus.laser_gfx   = 1'b0;
    bus.alien_pixel = 1'b0;
    bus.bomb_gfx    = 1'b0;
    bus.cannon_gfx  = 1'b0;
  endtask

  // One frame: set levels, play overlaps, then a vsync rising edge; returns #1 after the commit edge.
  task automatic run_frame(input vec_t v);
    @(negedge clk);
    bus.vsync          = 1'b0;
    bus.btn_start      = (v.btn != 0);
    bus.aliens_cleared = (v.clr != 0);
    bus.aliens_landed  = (v.land != 0);
    for (int k = 0; k < v.nl; k++) begin
      @(negedge clk);
      bus.display_on = (v.dis != 0); bus.laser_gfx = 1'b1; bus.alien_pixel = 1'b1;
      @(negedge clk);
      clear_pixels();
    end
    for (int k = 0; k < v.nb; k++) begin
      @(negedge clk);
      bus.display_on = (v.dis != 0); bus.bomb_gfx = 1'b1; bus.cannon_gfx = 1'b1;
      @(negedge clk);
      clear_pixels();
    end
    @(negedge clk);
    bus.vsync = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string nm, input vec_t v);
    chk({nm, "_state"}, int'(bus.game_state), v.st);
    chk({nm, "_score"}, int'(bus.score), v.sc);
    chk({nm, "_lives"}, int'(bus.lives), v.lv);
    chk({nm, "_wave"}, int'(bus.wave), v.wv);
    chk({nm, "_hit"}, int'(bus.hit_alien), v.h);
    chk({nm, "_frst"}, int'(bus.formation_rst), v.f);
    chk({nm, "_crst"}, int'(bus.cannon_rst), v.c);
    chk({nm, "_play"}, int'(bus.play_en), v.p);
  endtask

  initial begin
    //               btn nl  nb dis clr land reps  st  sc  lv wv h f c p
    vecs[0]  = mk(0,  0,  0, 1, 0, 0,   1,  0,  0, 3, 0, 0,0,0,0); // idle, no button
    vecs[1]  = mk(1,  0,  0, 1, 0, 0,   1,  1,  0, 3, 0, 0,1,1,1); // start
    vecs[2]  = mk(0,  1,  0, 1, 0, 0,   1,  1,  1, 3, 0, 1,0,0,1); // one hit
    vecs[3]  = mk(0,  0,  0, 1, 0, 0,   1,  1,  1, 3, 0, 0,0,0,1); // quiet frame
    vecs[4]  = mk(0, 20,  0, 1, 0, 0,   1,  1,  2, 3, 0, 1,0,0,1); // 20 overlaps, one point
    vecs[5]  = mk(0,  1,  0, 0, 0, 0,   1,  1,  2, 3, 0, 0,0,0,1); // overlap outside visible area
    vecs[6]  = mk(0,  0,  1, 1, 0, 0,   1,  2,  2, 2, 0, 0,0,0,0); // bomb hit
    vecs[7]  = mk(0,  1,  0, 1, 0, 0,  59,  2,  2, 2, 0, 0,0,0,0); // dying, laser ignored
    vecs[8]  = mk(0,  0,  0, 1, 0, 0,   1,  1,  2, 2, 0, 0,0,1,1); // respawn
    vecs[9]  = mk(0,  0,  0, 1, 1, 0,   1,  3,  2, 2, 0, 0,0,0,0); // wave cleared
    vecs[10] = mk(0,  0,  0, 1, 0, 0,  89,  3,  2, 2, 0, 0,0,0,0); // clear wait
    vecs[11] = mk(0,  0,  0, 1, 0, 0,   1,  1,  2, 2, 1, 0,1,0,1); // next wave
    vecs[12] = mk(0,  0,  1, 1, 0, 0,   1,  2,  2, 1, 1, 0,0,0,0); // bomb hit
    vecs[13] = mk(0,  0,  0, 1, 0, 0,  59,  2,  2, 1, 1, 0,0,0,0);
    vecs[14] = mk(0,  0,  0, 1, 0, 0,   1,  1,  2, 1, 1, 0,0,1,1);
    vecs[15] = mk(0,  1,  1, 1, 0, 0,   1,  4,  3, 0, 1, 1,0,0,0); // last life, hit + death
    vecs[16] = mk(1,  0,  0, 1, 0, 0,   1,  4,  3, 0, 1, 0,0,0,0); // held button ignored
    vecs[17] = mk(0,  0,  0, 1, 0, 0,   1,  4,  3, 0, 1, 0,0,0,0); // release
    vecs[18] = mk(1,  0,  0, 1, 0, 0,   1,  0,  3, 0, 1, 0,0,0,0); // press -> idle
    vecs[19] = mk(1,  0,  0, 1, 0, 0,   1,  1,  0, 3, 0, 0,1,1,1); // new game
    vecs[20] = mk(0,  0,  0, 1, 0, 1,   1,  4,  0, 0, 0, 0,0,0,0); // aliens landed
    vecs[21] = mk(0,  0,  0, 1, 0, 0,   1,  4,  0, 0, 0, 0,0,0,0);
    vecs[22] = mk(1,  0,  0, 1, 0, 0,   1,  0,  0, 0, 0, 0,0,0,0);
    vecs[23] = mk(1,  0,  0, 1, 0, 0,   1,  1,  0, 3, 0, 0,1,1,1);
    vecs[24] = mk(0,  1,  0, 1, 0, 0, 255,  1,255, 3, 0, 1,0,0,1); // fill to 255
    vecs[25] = mk(0,  1,  0, 1, 0, 0,   1,  1,255, 3, 0, 1,0,0,1); // saturated
    vecs[26] = mk(0,  0,  0, 1, 1, 0,   1,  3,255, 3, 0, 0,0,0,0); // wave clear again

    bus.vsync = 1'b0; bus.btn_start = 1'b0; bus.aliens_cleared = 1'b0; bus.aliens_landed = 1'b0;
    clear_pixels();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", mk(0,0,0,0,0,0,0, 0,0,3,0, 0,0,0,0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) run_frame(vecs[i]);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
      if (vecs[i].h != 0) exp_hits += vecs[i].reps;
    end

    // Reset on a frame_tick cycle mid-WAVE_CLEAR overrides the commit.
    for (int r = 0; r < 10; r++) run_frame(mk(0,0,0,1,0,0,1, 0,0,0,0, 0,0,0,0));
    chk("wc_mid_state", int'(bus.game_state), 3);
    @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    bus.vsync = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("mid_reset", mk(0,0,0,0,0,0,0, 0,0,3,0, 0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    bus.vsync = 1'b0;

    run_frame(mk(1,0,0,1,0,0,1, 0,0,0,0, 0,0,0,0));
    check_outputs("restart", mk(1,0,0,1,0,0,1, 1,0,3,0, 0,1,1,1));

    // Collision on the frame_tick cycle itself belongs to the following frame.
    @(negedge clk);
    bus.vsync = 1'b0;
    bus.btn_start = 1'b0;
    @(negedge clk);
    bus.vsync = 1'b1;
    bus.display_on = 1'b1; bus.laser_gfx = 1'b1; bus.alien_pixel = 1'b1;
    @(posedge clk);
    #1;
    chk("tick_hit_same_frame", int'(bus.hit_alien), 0);
    chk("tick_score_same_frame", int'(bus.score), 0);
    @(negedge clk);
    clear_pixels();
    run_frame(mk(0,0,0,1,0,0,1, 0,0,0,0, 0,0,0,0));
    chk("tick_hit_next_frame", int'(bus.hit_alien), 1);
    chk("tick_score_next_frame", int'(bus.score), 1);
    exp_hits += 1;

    @(negedge clk);
    @(negedge clk);
    chk("hit_pulse_cycles", hit_cycles, exp_hits);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
